stream8x2_hls_deadlock_reporter: RTL and testbench

//   Consumer of the per-instance deadlock monitor's `block` flag.

---
 rtl/stream8x2_hls_deadlock_reporter.sv | 104 ++++++++++
 tb/tb_stream8x2_hls_deadlock_reporter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/stream8x2_hls_deadlock_reporter.sv
// stream8x2_hls_deadlock_reporter: qualifies a persistent monitor block as deadlock and emits one AXIS report word
// Optional auto re-arm from LATCHED after 16 idle cycles: define DEADLOCK_RPT_REARM_EN
module stream8x2_hls_deadlock_reporter #(
    parameter int NUM_CH = 2,
    parameter int THRESH = 1024,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              block_in,
    input  logic [NUM_CH-1:0] axis_block_sigs,
    input  logic              clear,
    output logic [63:0]       rpt_tdata,
    output logic              rpt_tvalid,
    input  logic              rpt_tready,
    output logic              deadlock,
    output logic [CNT_W-1:0]  stall_cnt
);
    typedef enum logic [1:0] {IDLE, WATCH, REPORT, LATCHED} state_t;
    state_t state, state_n;
    logic [31:0] timestamp;
    logic [7:0] ch_mask, ch_mask_n, sigs, mask_acc;
    logic [CNT_W-1:0] stall_cnt_n;
    logic [63:0] rpt_tdata_n;
    logic rpt_tvalid_n, deadlock_n, rearm;
    assign sigs = 8'(axis_block_sigs);
    assign mask_acc = ch_mask | sigs;
`ifdef DEADLOCK_RPT_REARM_EN
    logic [3:0] idle_run;
    assign rearm = state == LATCHED && !block_in && idle_run == 4'd15;
    always_ff @(posedge clock or negedge reset)
        if (!reset)
            idle_run <= '0;
        else
            idle_run <= (state == LATCHED && !block_in && !clear) ? idle_run + 4'd1 : 4'd0;
`else
    assign rearm = 1'b0;
`endif
    always_ff @(posedge clock or negedge reset)
        if (!reset) begin
            state      <= IDLE;
            timestamp  <= '0;
            ch_mask    <= '0;
            stall_cnt  <= '0;
            rpt_tdata  <= '0;
            rpt_tvalid <= 1'b0;
            deadlock   <= 1'b0;
        end else begin
            state      <= state_n;
            timestamp  <= timestamp + 32'd1;
            ch_mask    <= ch_mask_n;
            stall_cnt  <= stall_cnt_n;
            rpt_tdata  <= rpt_tdata_n;
            rpt_tvalid <= rpt_tvalid_n;
            deadlock   <= deadlock_n;
        end
    always_comb begin
        state_n      = state;
        ch_mask_n    = ch_mask;
        stall_cnt_n  = stall_cnt;
        rpt_tdata_n  = rpt_tdata;
        rpt_tvalid_n = rpt_tvalid;
        deadlock_n   = deadlock;
        case (state)
            IDLE:
                if (block_in && !clear) begin
                    state_n     = WATCH;
                    stall_cnt_n = CNT_W'(1);
                    ch_mask_n   = sigs;
                end
            WATCH:
                if (clear || !block_in) begin
                    state_n     = IDLE;
                    stall_cnt_n = '0;
                    ch_mask_n   = '0;
                end else if (stall_cnt == CNT_W'(THRESH - 1)) begin
                    state_n      = REPORT;
                    stall_cnt_n  = CNT_W'(THRESH);
                    ch_mask_n    = mask_acc;
                    rpt_tvalid_n = 1'b1;
                    deadlock_n   = 1'b1;
                    rpt_tdata_n  = {timestamp, 16'(THRESH), 8'h00, mask_acc};
                end else begin
                    stall_cnt_n = stall_cnt + CNT_W'(1);
                    ch_mask_n   = mask_acc;
                end
            // tvalid is never withdrawn once raised, so clear and block_in are ignored here
            REPORT:
                if (rpt_tready) begin
                    state_n      = LATCHED;
                    rpt_tvalid_n = 1'b0;
                end
            LATCHED:
                if (clear || rearm) begin
                    state_n     = IDLE;
                    deadlock_n  = 1'b0;
                    stall_cnt_n = '0;
                    ch_mask_n   = '0;
                    rpt_tdata_n = '0;
                end
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_stream8x2_hls_deadlock_reporter.sv
// tb_stream8x2_hls_deadlock_reporter: directed checks with THRESH=8, NUM_CH=2
module tb_stream8x2_hls_deadlock_reporter;
    logic clock = 1'b0;
    logic reset, block_in, clear, rpt_tvalid, rpt_tready, deadlock;
    logic [1:0] axis_block_sigs;
    logic [63:0] rpt_tdata;
    logic [15:0] stall_cnt;
    int tests = 0;
    int errors = 0;

    stream8x2_hls_deadlock_reporter #(.NUM_CH(2), .THRESH(8), .CNT_W(16)) dut (
        .clock(clock), .reset(reset), .block_in(block_in), .axis_block_sigs(axis_block_sigs),
        .clear(clear), .rpt_tdata(rpt_tdata), .rpt_tvalid(rpt_tvalid), .rpt_tready(rpt_tready),
        .deadlock(deadlock), .stall_cnt(stall_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        reset = 1'b0; block_in = 1'b0; axis_block_sigs = 2'b00; clear = 1'b0; rpt_tready = 1'b1;
        repeat (2) @(negedge clock);
        check("rst_tvalid", rpt_tvalid, 0);
        check("rst_tdata", rpt_tdata, 0);
        check("rst_deadlock", deadlock, 0);
        check("rst_cnt", stall_cnt, 0);
        reset = 1'b1;
        // T1: report on edge 8, timestamp 7
        block_in = 1'b1; axis_block_sigs = 2'b01;
        repeat (7) tick();
        check("t1_no_early", rpt_tvalid, 0);
        check("t1_cnt7", stall_cnt, 7);
        tick();
        check("t1_tvalid", rpt_tvalid, 1);
        check("t1_tdata", rpt_tdata, {32'd7, 16'd8, 8'h00, 8'h01});
        check("t1_deadlock", deadlock, 1);
        check("t1_cnt_sat", stall_cnt, 8);
        block_in = 1'b0;
        tick();
        check("t1_one_cycle", rpt_tvalid, 0);
        check("t1_sticky", deadlock, 1);
        check("t1_cnt_hold", stall_cnt, 8);
        clear = 1'b1;
        tick();
        check("t1_clr_dl", deadlock, 0);
        check("t1_clr_cnt", stall_cnt, 0);
        check("t1_clr_tdata", rpt_tdata, 0);
        clear = 1'b0;
        // T2: broken burst does not report
        block_in = 1'b1;
        repeat (7) tick();
        check("t2_cnt7", stall_cnt, 7);
        block_in = 1'b0;
        tick();
        check("t2_cnt0", stall_cnt, 0);
        check("t2_no_rpt", rpt_tvalid, 0);
        block_in = 1'b1;
        repeat (7) tick();
        check("t2_no_early", rpt_tvalid, 0);
        tick();
        check("t2_tvalid", rpt_tvalid, 1);
        check("t2_tdata", rpt_tdata, {32'd25, 16'd8, 8'h00, 8'h01});
        block_in = 1'b0;
        tick();
        check("t2_done", rpt_tvalid, 0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        // T3/T4: mask accumulation, then backpressure with clear pulse
        rpt_tready = 1'b0; block_in = 1'b1; axis_block_sigs = 2'b01;
        repeat (3) tick();
        axis_block_sigs = 2'b10;
        repeat (5) tick();
        check("t3_tvalid", rpt_tvalid, 1);
        check("t3_tdata", rpt_tdata, {32'd35, 16'd8, 8'h00, 8'h03});
        for (int i = 0; i < 5; i++) begin
            clear = (i == 1);
            block_in = (i % 2 == 0);
            tick();
            check("t4_hold_valid", rpt_tvalid, 1);
            check("t4_hold_data", rpt_tdata, {32'd35, 16'd8, 8'h00, 8'h03});
        end
        clear = 1'b0; rpt_tready = 1'b1; block_in = 1'b0;
        tick();
        check("t4_xfer", rpt_tvalid, 0);
        check("t4_deadlock", deadlock, 1);
        check("t4_cnt", stall_cnt, 8);
        tick();
        check("t4_single", rpt_tvalid, 0);
        // T5: clear, clear-beats-block, second report
        clear = 1'b1; block_in = 1'b1;
        tick();
        check("t5_clr_dl", deadlock, 0);
        check("t5_clr_cnt", stall_cnt, 0);
        tick();
        check("t5_clr_idle", stall_cnt, 0);
        clear = 1'b0;
        repeat (3) tick();
        check("t5_cnt3", stall_cnt, 3);
        clear = 1'b1;
        tick();
        check("t5_clr_watch", stall_cnt, 0);
        clear = 1'b0;
        repeat (8) tick();
        check("t5_tvalid", rpt_tvalid, 1);
        check("t5_tdata", rpt_tdata, {32'd56, 16'd8, 8'h00, 8'h02});
        check("t5_ts_later", rpt_tdata[63:32] > 32'd7, 1);
        block_in = 1'b0;
        tick();
        check("t5_xfer", rpt_tvalid, 0);
        // LATCHED with block_in low: only the re-arm build leaves on its own
        repeat (15) tick();
        check("rearm_15", deadlock, 1);
        tick();
`ifdef DEADLOCK_RPT_REARM_EN
        check("rearm_16", deadlock, 0);
`else
        check("no_rearm_16", deadlock, 1);
`endif
        clear = 1'b1;
        tick();
        clear = 1'b0;
        // T6: asynchronous reset mid-REPORT
        rpt_tready = 1'b0; block_in = 1'b1;
        repeat (8) tick();
        check("t6_tvalid", rpt_tvalid, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_tvalid", rpt_tvalid, 0);
        check("t6_async_tdata", rpt_tdata, 0);
        check("t6_async_dl", deadlock, 0);
        check("t6_async_cnt", stall_cnt, 0);
        @(negedge clock);
        reset = 1'b1;
        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
